dmem_responder: RTL and testbench

- Data-memory responder for the single-cycle CPU's data port. It is the memory end of the `dmem_addr` / `dmem_data` / `dmem_we` / `dmem_out` interface.
- Word-addressed storage array fronted by a posted write buffer. Stores are accepted every cycle without stalling the CPU; buffered stores drain into the array in idle or forced cycles.
- Loads are answered combinationally in the same cycle. Data still sitting in the buffer is forwarded, so the CPU always sees program-order memory contents.

---
 rtl/dmem_if.sv | 25 ++
 rtl/dmem_responder.sv | 98 +++++++++
 tb/tb_dmem_responder.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// CPU data-port bundle between the single-cycle core (master) and the data memory (slave).
// dmem_we qualifies dmem_addr/dmem_data as a store in the cycle it is high; there is no ready, the slave accepts every cycle.
interface dmem_if #(
  parameter int WB_DEPTH = 4,
  parameter int CW       = $clog2(WB_DEPTH + 1)
) ();
  logic [31:0]   dmem_addr;
  logic [31:0]   dmem_data;
  logic          dmem_we;
  logic          flush;
  logic [31:0]   dmem_out;
  logic [CW-1:0] wb_count;
  logic          wb_empty;
  logic          wb_full;

  modport master (
    output dmem_addr, dmem_data, dmem_we, flush,
    input  dmem_out, wb_count, wb_empty, wb_full
  );

  modport slave (
    input  dmem_addr, dmem_data, dmem_we, flush,
    output dmem_out, wb_count, wb_empty, wb_full
  );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory behind a posted write buffer; loads are combinational and
// forward the youngest buffered store to the same word so the CPU sees program order.
module dmem_responder #(
  parameter int AW       = 10,
  parameter int WB_DEPTH = 4,
  parameter int CW       = $clog2(WB_DEPTH + 1)
) (
  input logic  clk,
  input logic  reset,
  dmem_if.slave bus
);
  localparam int PW = $clog2(WB_DEPTH);

  logic [AW-1:0]       wb_addr  [WB_DEPTH];
  logic [31:0]         wb_data  [WB_DEPTH];
  logic [WB_DEPTH-1:0] wb_valid;
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;
  logic [31:0]         mem      [2**AW];

  logic [AW-1:0] laddr;
  logic          empty;
  logic          full;
  logic          push;
  logic          drain;
  logic          fwd_hit;
  logic [31:0]   fwd_data;
  logic [PW-1:0] idx;
  logic          unused_addr_bits;

  // Upper address bits alias onto the low AW bits.
  assign laddr            = bus.dmem_addr[AW-1:0];
  assign unused_addr_bits = ^bus.dmem_addr[31:AW];

  assign empty = (count == '0);
  assign full  = (count == CW'(WB_DEPTH));
  assign push  = bus.dmem_we;
  // When full, a push forces a drain so the freed slot takes the new store.
  assign drain = !empty && (!bus.dmem_we || full || bus.flush);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      wb_valid <= '0;
      for (int i = 0; i < WB_DEPTH; i++) begin
        wb_addr[i] <= '0;
        wb_data[i] <= '0;
      end
    end else begin
      if (drain) begin
        wb_valid[head] <= 1'b0;
        head           <= head + 1'b1;
      end
      if (push) begin
        wb_addr[tail]  <= laddr;
        wb_data[tail]  <= bus.dmem_data;
        wb_valid[tail] <= 1'b1;
        tail           <= tail + 1'b1;
      end
      case ({push, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Single array write port, used only by the drain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    end else if (drain) begin
      mem[wb_addr[head]] <= wb_data[head];
    end
  end

  // Walk oldest to youngest so the last match found is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      idx = head + PW'(k);
      if (wb_valid[idx] && (wb_addr[idx] == laddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = wb_data[idx];
      end
    end
  end

  assign bus.dmem_out = fwd_hit ? fwd_data : mem[laddr];
  assign bus.wb_count = count;
  assign bus.wb_empty = empty;
  assign bus.wb_full  = full;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: hand-computed expectations checked with immediate assertions.
module tb_dmem_responder;
  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  dmem_if #(.WB_DEPTH(4)) bus ();

  dmem_responder #(.AW(10), .WB_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] data,
                       input logic we, input logic fl);
    bus.dmem_addr = addr;
    bus.dmem_data = data;
    bus.dmem_we   = we;
    bus.flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_count(input string tag, input int exp);
    check(tag, 32'(bus.wb_count), 32'(exp));
  endtask

  initial begin
    logic [31:0] exp_cnt [6];
    n_cmp = 0;
    n_err = 0;
    exp_cnt = '{1, 2, 3, 4, 4, 4};

    // Reset
    reset = 1'b0;
    drive(32'd5, 32'd0, 1'b0, 1'b0);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("reset_out", bus.dmem_out, 32'h0);
    check_count("reset_count", 0);
    check("reset_empty", 32'(bus.wb_empty), 32'd1);
    check("reset_full", 32'(bus.wb_full), 32'd0);

    // Store then idle
    drive(32'd3, 32'h12345678, 1'b1, 1'b0);
    check("store_not_visible_yet", bus.dmem_out, 32'h0);
    tick();
    drive(32'd3, 32'h0, 1'b0, 1'b0);
    check_count("store_count1", 1);
    check("store_fwd", bus.dmem_out, 32'h12345678);
    tick();
    check_count("store_count0", 0);
    check("store_array", bus.dmem_out, 32'h12345678);
    tick();
    check("store_array_idle", bus.dmem_out, 32'h12345678);

    // Burst of six stores never stalls
    for (int i = 0; i < 6; i++) begin
      drive(32'(i), 32'hA0 + 32'(i), 1'b1, 1'b0);
      tick();
      check_count($sformatf("burst_count%0d", i), int'(exp_cnt[i]));
      check($sformatf("burst_full%0d", i), 32'(bus.wb_full), (i >= 3) ? 32'd1 : 32'd0);
    end
    drive(32'd5, 32'h0, 1'b0, 1'b0);
    check("burst_fwd5", bus.dmem_out, 32'hA5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_count($sformatf("burst_drain%0d", i), 3 - i);
    end
    for (int i = 0; i < 6; i++) begin
      drive(32'(i), 32'h0, 1'b0, 1'b0);
      check($sformatf("burst_read%0d", i), bus.dmem_out, 32'hA0 + 32'(i));
    end

    // Same-address forwarding picks the youngest entry
    drive(32'd7, 32'h1, 1'b1, 1'b0);
    tick();
    drive(32'd7, 32'h2, 1'b1, 1'b0);
    tick();
    drive(32'd7, 32'h0, 1'b0, 1'b0);
    check_count("same_count2", 2);
    check("same_fwd_young", bus.dmem_out, 32'h2);
    tick();
    check_count("same_count1", 1);
    check("same_mid_drain", bus.dmem_out, 32'h2);
    tick();
    check_count("same_count0", 0);
    check("same_array", bus.dmem_out, 32'h2);

    // Aliasing: 0x400 maps to word 0
    drive(32'h400, 32'hDEAD, 1'b1, 1'b0);
    tick();
    drive(32'h0, 32'h0, 1'b0, 1'b0);
    check("alias_fwd", bus.dmem_out, 32'hDEAD);
    tick();
    check("alias_array", bus.dmem_out, 32'hDEAD);

    // Flush drains one per cycle
    for (int i = 0; i < 3; i++) begin
      drive(32'd10 + 32'(i), 32'h10 + 32'(i), 1'b1, 1'b0);
      tick();
    end
    check_count("flush_pre", 3);
    drive(32'd12, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_count($sformatf("flush_drain%0d", i), 2 - i);
    end
    tick();
    check_count("flush_empty_count", 0);
    check("flush_empty_flag", 32'(bus.wb_empty), 32'd1);
    check("flush_read12", bus.dmem_out, 32'h12);

    // Flush with stores every cycle keeps the count steady
    for (int i = 0; i < 3; i++) begin
      drive(32'd20 + 32'(i), 32'h20 + 32'(i), 1'b1, 1'b0);
      tick();
    end
    for (int i = 0; i < 2; i++) begin
      drive(32'd23 + 32'(i), 32'h23 + 32'(i), 1'b1, 1'b1);
      tick();
      check_count($sformatf("flush_we_count%0d", i), 3);
    end
    drive(32'd20, 32'h0, 1'b0, 1'b0);
    check("flush_we_read20", bus.dmem_out, 32'h20);
    for (int i = 0; i < 3; i++) tick();
    check_count("flush_we_done", 0);
    drive(32'd24, 32'h0, 1'b0, 1'b0);
    check("flush_we_read24", bus.dmem_out, 32'h24);

    // Reset mid-operation discards buffered stores
    drive(32'd30, 32'h30, 1'b1, 1'b0);
    tick();
    drive(32'd31, 32'h31, 1'b1, 1'b0);
    tick();
    check_count("midrst_pre", 2);
    drive(32'd30, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    check_count("midrst_count", 0);
    check("midrst_empty", 32'(bus.wb_empty), 32'd1);
    check("midrst_out30", bus.dmem_out, 32'h0);
    tick();
    reset = 1'b1;
    #1;
    tick();
    check("midrst_read30", bus.dmem_out, 32'h0);
    drive(32'd31, 32'h0, 1'b0, 1'b0);
    check("midrst_read31", bus.dmem_out, 32'h0);
    drive(32'd3, 32'h0, 1'b0, 1'b0);
    check("midrst_read3_cleared", bus.dmem_out, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
